// File: rtl/lbp_hist.sv
// lbp_hist: folds the LBP stage's 8-bit codes into a 59-bin uniform-pattern histogram for one
// 128x128 frame, then streams the bins out over a valid/ready handshake.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   lbp_valid/addr/data    incoming code stream (addr row = [13:7], col = [6:0])
//   finish                 producer frame complete (level)
//   hist_valid/ready       drain handshake
//   hist_bin/hist_count    bin index being offered and its count
//   total                  codes accepted this frame (saturating)
//   border_err             sticky: a code arrived for a border pixel
//   done                   all bins transferred; held until reset
module lbp_hist #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned CNT_W = 14,
  parameter int unsigned NBINS = 59
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [5:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic [13:0]      total,
  output logic             border_err,
  output logic             done
);

  localparam int unsigned     COL_W    = $clog2(IMG_W);
  localparam logic [COL_W-1:0] EDGE_MAX = COL_W'(IMG_W - 1);
  localparam logic [5:0]      LAST_BIN = 6'(NBINS - 1);

  typedef enum logic [1:0] {StAccum, StDrain, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] bins_q [NBINS];
  logic [5:0]       bin_lut [256];
  logic [5:0]       bin_sel;
  logic [COL_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             interior;

  // Uniform: at most two 0/1 transitions walking the byte circularly.
  function automatic logic is_uniform(input logic [7:0] code);
    logic [7:0] rot;
    rot = {code[0], code[7:1]};
    return $countones(code ^ rot) <= 2;
  endfunction

  // Constant table: uniform codes numbered in ascending code order, the rest share the last bin.
  always_comb begin : gen_lut
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < 256; i++) begin
      if (is_uniform(8'(i))) begin
        bin_lut[i] = idx;
        idx        = idx + 6'd1;
      end else begin
        bin_lut[i] = LAST_BIN;
      end
    end
  end

  assign bin_sel  = bin_lut[lbp_data];
  assign row      = lbp_addr[2*COL_W-1:COL_W];
  assign col      = lbp_addr[COL_W-1:0];
  assign interior = (row != '0) && (row != EDGE_MAX) && (col != '0) && (col != EDGE_MAX);

  // Bins never change outside ACCUM, so a direct read stays stable across drain stalls.
  assign hist_count = (hist_bin <= LAST_BIN) ? bins_q[hist_bin] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StAccum;
      for (int i = 0; i < int'(NBINS); i++) begin
        bins_q[i] <= '0;
      end
      total      <= '0;
      hist_valid <= 1'b0;
      hist_bin   <= '0;
      border_err <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_q)
        StAccum: begin
          // A code arriving on the finish edge is still folded in.
          if (lbp_valid) begin
            if (interior) begin
              if (bins_q[bin_sel] != '1) begin
                bins_q[bin_sel] <= bins_q[bin_sel] + CNT_W'(1);
              end
              if (total != '1) begin
                total <= total + 14'd1;
              end
            end else begin
              border_err <= 1'b1;
            end
          end
          if (finish) begin
            state_q    <= StDrain;
            hist_valid <= 1'b1;
            hist_bin   <= '0;
          end
        end
        StDrain: begin
          if (hist_ready) begin
            if (hist_bin == LAST_BIN) begin
              hist_valid <= 1'b0;
              done       <= 1'b1;
              state_q    <= StDone;
            end else begin
              hist_bin <= hist_bin + 6'd1;
            end
          end
        end
        StDone: begin
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_hist.sv
module tb_lbp_hist;

  logic        clk = 1'b0;
  logic        reset;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        hist_valid;
  logic        hist_ready;
  logic [5:0]  hist_bin;
  logic [13:0] hist_count;
  logic [13:0] total;
  logic        border_err;
  logic        done;

  lbp_hist dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .total      (total),
    .border_err (border_err),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  data;
    int          exp_bin;
    bit          exp_border;
  } vec_t;

  vec_t vecs [16];

  int n_pass  = 0;
  int n_total = 0;

  int cap [59];
  int n_emit;
  int done_cyc;
  int first_valid_cyc;
  int order_errs;
  int stall_errs;
  int stall_cycles;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int cap_sum();
    int s = 0;
    for (int i = 0; i < 59; i++) if (cap[i] > 0) s += cap[i];
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; finish = 1'b0; lbp_valid = 1'b0; hist_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk);
    lbp_valid = 1'b1; lbp_addr = a; lbp_data = d;
  endtask

  // Raises finish at the next negedge (cycle 0 of the drain count).
  task automatic raise_finish();
    @(negedge clk);
    lbp_valid = 1'b0; finish = 1'b1;
  endtask

  // mode 0: ready high; 1: stall 5 cycles at bin 10 then toggle; 2: reset when bin 20 offered.
  task automatic drain(input int mode, input int max_cyc);
    int  cyc = 0;
    int  stall_left = 0;
    bit  stalled_once = 0;
    bit  tog = 0;
    bit  r;
    bit  prev_stall = 0;
    int  pb = 0;
    int  pc = 0;
    for (int i = 0; i < 59; i++) cap[i] = -1;
    n_emit = 0; done_cyc = -1; first_valid_cyc = -1;
    order_errs = 0; stall_errs = 0; stall_cycles = 0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      lbp_valid = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (hist_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (mode == 2 && hist_valid && hist_bin == 6'd20) begin
        reset = 1'b1; finish = 1'b0; hist_ready = 1'b0;
        break;
      end
      r = 1'b1;
      if (mode == 1) begin
        if (!stalled_once && hist_valid && hist_bin == 6'd10) begin
          stall_left = 5; stalled_once = 1;
        end
        if (stall_left > 0) begin
          r = 1'b0; stall_left--;
        end else if (stalled_once) begin
          r = tog; tog = !tog;
        end
      end
      if (prev_stall && (int'(hist_bin) != pb || int'(hist_count) != pc)) stall_errs++;
      hist_ready = r;
      if (hist_valid && r) begin
        if (int'(hist_bin) != n_emit) order_errs++;
        if (hist_bin < 6'd59) cap[hist_bin] = int'(hist_count);
        n_emit++;
      end
      prev_stall = hist_valid && !r;
      if (prev_stall) stall_cycles++;
      pb = int'(hist_bin);
      pc = int'(hist_count);
    end
  endtask

  initial begin
    reset = 1'b1; lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0;
    finish = 1'b0; hist_ready = 1'b0;

    vecs[0]  = '{14'h0081, 8'h00, 0,  1'b0};
    vecs[1]  = '{14'h0102, 8'h01, 1,  1'b0};
    vecs[2]  = '{14'h0203, 8'h02, 2,  1'b0};
    vecs[3]  = '{14'h1F44, 8'h04, 4,  1'b0};
    vecs[4]  = '{14'h2050, 8'h08, 7,  1'b0};
    vecs[5]  = '{14'h3001, 8'h0C, 8,  1'b0};
    vecs[6]  = '{14'h0A0A, 8'h80, 29, 1'b0};
    vecs[7]  = '{14'h0B0B, 8'h81, 30, 1'b0};
    vecs[8]  = '{14'h0C0C, 8'hC1, 37, 1'b0};
    vecs[9]  = '{14'h0D0D, 8'hFE, 56, 1'b0};
    vecs[10] = '{14'h0E0E, 8'h11, 58, 1'b0};
    vecs[11] = '{14'h3F7E, 8'hFF, 57, 1'b0};
    vecs[12] = '{14'h0080, 8'h00, 0,  1'b1};
    vecs[13] = '{14'h3F81, 8'h03, 3,  1'b1};
    vecs[14] = '{14'h007F, 8'h07, 6,  1'b1};
    vecs[15] = '{14'h00FF, 8'h06, 5,  1'b1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_hist_valid", int'(hist_valid), 0);
    check("rst_hist_bin", int'(hist_bin), 0);
    check("rst_hist_count", int'(hist_count), 0);
    check("rst_total", int'(total), 0);
    check("rst_border_err", int'(border_err), 0);
    check("rst_done", int'(done), 0);

    // One code per frame
    for (int v = 0; v < 16; v++) begin
      do_reset();
      send(vecs[v].addr, vecs[v].data);
      raise_finish();
      drain(0, 200);
      check($sformatf("vec%0d_bin%0d", v, vecs[v].exp_bin), cap[vecs[v].exp_bin],
            vecs[v].exp_border ? 0 : 1);
      check($sformatf("vec%0d_total", v), int'(total), vecs[v].exp_border ? 0 : 1);
      check($sformatf("vec%0d_sum", v), cap_sum(), vecs[v].exp_border ? 0 : 1);
      check($sformatf("vec%0d_border", v), int'(border_err), int'(vecs[v].exp_border));
      check($sformatf("vec%0d_emitted", v), n_emit, 59);
    end

    // Three back-to-back codes into the same bin; drain timing
    do_reset();
    for (int k = 0; k < 3; k++) send(14'h0081, 8'h00);
    raise_finish();
    drain(0, 200);
    check("b2b_bin0", cap[0], 3);
    check("b2b_sum", cap_sum(), 3);
    check("b2b_total", int'(total), 3);
    check("b2b_first_valid_latency", first_valid_cyc, 1);
    check("b2b_done_cycle", done_cyc, 60);
    check("b2b_order", order_errs, 0);
    check("b2b_valid_after_done", int'(hist_valid), 0);

    // Mixed uniform / non-uniform codes
    do_reset();
    send(14'h0505, 8'h05);
    send(14'h0506, 8'h55);
    send(14'h0507, 8'hFF);
    send(14'h0508, 8'h06);
    raise_finish();
    drain(0, 200);
    check("mix_bin58", cap[58], 2);
    check("mix_bin57", cap[57], 1);
    check("mix_bin5", cap[5], 1);
    check("mix_sum", cap_sum(), 4);
    check("mix_total", int'(total), 4);
    check("mix_border", int'(border_err), 0);

    // Border codes discarded, border_err sticky through done
    do_reset();
    send(14'h0080, 8'h00);
    send(14'h3F81, 8'h03);
    raise_finish();
    drain(0, 200);
    check("border_sum", cap_sum(), 0);
    check("border_total", int'(total), 0);
    check("border_done", int'(done), 1);
    repeat (3) @(negedge clk);
    check("border_err_held", int'(border_err), 1);

    // Full interior frame, last code on the finish edge
    do_reset();
    for (int r = 1; r <= 126; r++) begin
      for (int c = 1; c <= 126; c++) begin
        @(negedge clk);
        lbp_valid = 1'b1;
        lbp_addr  = 14'((r << 7) | c);
        lbp_data  = 8'h07;
        if (r == 126 && c == 126) finish = 1'b1;
      end
    end
    drain(0, 200);
    check("full_bin6", cap[6], 15876);
    check("full_sum", cap_sum(), 15876);
    check("full_total", int'(total), 15876);
    check("full_border", int'(border_err), 0);

    // Drain with backpressure
    do_reset();
    send(14'h0101, 8'h0F);
    send(14'h0102, 8'h0F);
    send(14'h0103, 8'h1F);
    send(14'h0104, 8'h00);
    raise_finish();
    drain(1, 400);
    check("stall_emitted", n_emit, 59);
    check("stall_order", order_errs, 0);
    check("stall_stable", stall_errs, 0);
    check("stall_seen", int'(stall_cycles >= 5), 1);
    check("stall_bin10", cap[10], 2);
    check("stall_bin15", cap[15], 1);
    check("stall_bin0", cap[0], 1);
    check("stall_done", int'(done_cyc > 0), 1);

    // Reset mid-drain, then a fresh frame from zero
    do_reset();
    send(14'h0101, 8'h01);
    raise_finish();
    drain(2, 200);
    @(negedge clk);
    check("abort_hist_valid", int'(hist_valid), 0);
    check("abort_hist_bin", int'(hist_bin), 0);
    check("abort_hist_count", int'(hist_count), 0);
    check("abort_total", int'(total), 0);
    check("abort_done", int'(done), 0);
    reset = 1'b0;
    send(14'h0202, 8'h03);
    raise_finish();
    drain(0, 200);
    check("refill_bin3", cap[3], 1);
    check("refill_bin1", cap[1], 0);
    check("refill_total", int'(total), 1);
    check("refill_done", int'(done_cyc > 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lbp_hist.md
Name: lbp_hist

Overview:
- Downstream consumer of the LBP stage's output stream (lbp_valid / lbp_addr / lbp_data / finish) for a 128x128 image.
- Folds each 8-bit LBP code into a 59-bin uniform-pattern histogram.
- After the producer raises finish, streams the bins out over a valid/ready handshake, then signals done.
- Sits between the LBP stage and the feature/classifier memory.

Parameters:
- IMG_W, 128, image width in pixels; power of two, log2 = 7 (address column field is lbp_addr[6:0])
- CNT_W, 14, bin counter width; bins saturate at 2^CNT_W-1
- NBINS, 59, number of bins: 58 uniform codes plus 1 non-uniform bin (fixed)

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; clears everything on the clk edge where sampled high
- lbp_valid  in  1  one-cycle strobe: lbp_addr/lbp_data valid this cycle
- lbp_addr  in  14  pixel address, row = [13:7], col = [6:0]
- lbp_data  in  8  LBP code for that pixel
- finish  in  1  producer frame complete (level; stays high)
- hist_valid  out  1  hist_bin/hist_count valid
- hist_ready  in  1  consumer accepts the current bin
- hist_bin  out  6  bin index 0..58
- hist_count  out  CNT_W  occurrences for hist_bin
- total  out  14  number of codes accepted into the histogram this frame
- border_err  out  1  sticky: a valid code arrived for a border pixel
- done  out  1  all 59 bins transferred; held until reset

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high, port name reset.
- Reset values: all 59 bins = 0, total = 0, hist_valid = 0, hist_bin = 0, hist_count = 0, border_err = 0, done = 0, state = ACCUM.
- Reset mid-drain or mid-frame aborts immediately, with no further handshake.
- States: ACCUM -> DRAIN -> DONE. There is no other exit; only reset returns to ACCUM.
- Bin mapping:
  - A code is uniform if its circular bit-transition count (b7 wrapping to b0) is at most 2.
  - Uniform codes take bins 0..57 in ascending code order.
  - Examples: 0x00->0, 0x01->1, 0x02->2, 0x03->3, 0x04->4, 0x06->5, 0x07->6, 0x08->7, 0xFF->57.
  - All non-uniform codes (e.g. 0x05, 0x55) map to bin 58.
- ACCUM, on lbp_valid:
  - If row or col is 0 or 127, the code is discarded and border_err is set (sticky).
  - Otherwise the mapped bin increments by 1 (saturating at 2^CNT_W-1) and total increments (saturating at 16383).
  - The update is visible the next cycle. Back-to-back lbp_valid on consecutive cycles, including the same bin twice, must count every code.
- ACCUM -> DRAIN:
  - Taken at the edge where finish=1.
  - An lbp_valid in that same cycle is still counted before the transition.
  - On entering DRAIN: hist_valid=1, hist_bin=0.
- DRAIN:
  - hist_count always reflects the bin selected by hist_bin.
  - Handshake completes on a cycle with hist_valid & hist_ready; then hist_bin advances by 1.
  - While hist_ready=0, hist_bin and hist_count hold stable.
  - lbp_valid is ignored in DRAIN and DONE.
  - When the handshake on bin 58 completes: next cycle hist_valid=0, done=1, state=DONE.
- DONE: all outputs hold; bins and total are retained for debug reads.
- Throughput: one bin per cycle with hist_ready tied high, so the drain takes 59 cycles.
- Latency: finish edge to first hist_valid is 1 cycle.

Test Plan:
- Reset, then inject lbp_valid with addr=0x0081 (row 1, col 1) and data=0x00 for 3 cycles back-to-back, then finish=1 with hist_ready=1 -> bin0 count=3, all other bins 0, total=3, done asserts 60 cycles after the finish edge.
- Codes 0x05, 0x55, 0xFF, 0x06 at interior addresses -> bin58=2, bin57=1, bin5=1, total=4, border_err=0.
- lbp_valid at addr 0x0080 (col 0) and 0x3F81 (row 127) -> no bin changes, total=0, border_err=1 and stays 1 through done.
- Full 126x126 frame, every code 0x07 -> bin6 count=15876, total=15876; lbp_valid coinciding with the finish edge is included.
- In DRAIN, hold hist_ready=0 for 5 cycles at hist_bin=10, then toggle hist_ready every other cycle -> bin/count stable while stalled, each bin emitted exactly once, bins in order 0..58.
- Assert reset at hist_bin=20 during DRAIN -> next cycle hist_valid=0, all bins 0, state ACCUM; a new frame then accumulates from zero.
